// File: rtl/multicycle_ctr.sv
// multicycle_ctr: main control FSM of the multicycle MIPS CPU (IF/ID/EX/MEM/WB/BR/JMP).
// Define MULTICYCLE_MEMWAIT_EN to honour the mem_ready handshake; otherwise memory is single-cycle.
module multicycle_ctr (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       mem_ready,
    output logic [2:0] ALUop,
    output logic       alu_src,
    output logic       ext_sign,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       pc_write,
    output logic       branch,
    output logic       branch_ne,
    output logic       jump,
    output logic       jump_reg,
    output logic       link,
    output logic       illegal,
    output logic [2:0] state
);

    localparam logic [2:0] S_IF  = 3'd0;
    localparam logic [2:0] S_ID  = 3'd1;
    localparam logic [2:0] S_EX  = 3'd2;
    localparam logic [2:0] S_MEM = 3'd3;
    localparam logic [2:0] S_WB  = 3'd4;
    localparam logic [2:0] S_BR  = 3'd5;
    localparam logic [2:0] S_JMP = 3'd6;

    localparam logic [5:0] OP_R     = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FUNCT_JR = 6'b001000;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUBU  = 3'b001;
    localparam logic [2:0] ALU_RTYPE = 3'b010;
    localparam logic [2:0] ALU_AND   = 3'b011;
    localparam logic [2:0] ALU_OR    = 3'b100;
    localparam logic [2:0] ALU_LUI   = 3'b101;
    localparam logic [2:0] ALU_SLTU  = 3'b110;
    localparam logic [2:0] ALU_SLT   = 3'b111;

    logic [2:0] state_q;
    logic [2:0] state_d;
    logic [5:0] op_q;
    logic       jr_q;
    logic       mem_rdy;
    logic       id_legal;

    function automatic logic op_legal(input logic [5:0] op);
        case (op)
            OP_R, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI, OP_SLTI, OP_SLTIU,
            OP_ANDI, OP_ORI, OP_LUI, OP_LW, OP_SW: op_legal = 1'b1;
            default:                               op_legal = 1'b0;
        endcase
    endfunction

`ifdef MULTICYCLE_MEMWAIT_EN
    assign mem_rdy = mem_ready;
`else
    // Single-cycle memory: the handshake is tied off but the port stays referenced.
    assign mem_rdy = mem_ready | 1'b1;
`endif

    assign id_legal = op_legal(opcode);

    always_comb begin
        state_d = S_IF;
        case (state_q)
            S_IF:  state_d = mem_rdy ? S_ID : S_IF;
            S_ID: begin
                if ((opcode == OP_BEQ) || (opcode == OP_BNE))
                    state_d = S_BR;
                else if ((opcode == OP_J) || (opcode == OP_JAL))
                    state_d = S_JMP;
                else if (!id_legal)
                    state_d = S_IF;
                else
                    state_d = S_EX;
            end
            S_EX: begin
                if ((op_q == OP_LW) || (op_q == OP_SW))
                    state_d = S_MEM;
                else if (jr_q)
                    state_d = S_IF;
                else
                    state_d = S_WB;
            end
            S_MEM: begin
                if (!mem_rdy)
                    state_d = S_MEM;
                else if (op_q == OP_LW)
                    state_d = S_WB;
                else
                    state_d = S_IF;
            end
            default: state_d = S_IF;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IF;
            op_q    <= 6'd0;
            jr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == S_ID) begin
                op_q <= opcode;
                jr_q <= (opcode == OP_R) && (funct == FUNCT_JR);
            end
        end
    end

    // Moore outputs from state/op_q; reset masks them combinationally so
    // in-flight writes drop in the very cycle reset rises.
    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        ALUop      = ALU_ADD;
        alu_src    = 1'b0;
        ext_sign   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        branch     = 1'b0;
        branch_ne  = 1'b0;
        jump       = 1'b0;
        jump_reg   = 1'b0;
        link       = 1'b0;
        illegal    = 1'b0;
        state      = S_IF;
        if (!reset) begin
            state = state_q;
            case (state_q)
                S_IF: begin
                    mem_read = 1'b1;
                    ir_write = mem_rdy;
                    pc_write = mem_rdy;
                end
                S_ID: illegal = !id_legal;
                S_EX: begin
                    case (op_q)
                        OP_R:                 ALUop = ALU_RTYPE;
                        OP_ANDI:              ALUop = ALU_AND;
                        OP_ORI:               ALUop = ALU_OR;
                        OP_LUI:               ALUop = ALU_LUI;
                        OP_SLTIU:             ALUop = ALU_SLTU;
                        OP_SLTI:              ALUop = ALU_SLT;
                        default:              ALUop = ALU_ADD;
                    endcase
                    alu_src  = (op_q != OP_R);
                    ext_sign = (op_q == OP_ADDI) || (op_q == OP_SLTI) || (op_q == OP_SLTIU) ||
                               (op_q == OP_LW)   || (op_q == OP_SW);
                    pc_write = jr_q;
                    jump_reg = jr_q;
                end
                S_MEM: begin
                    mem_read  = (op_q == OP_LW);
                    mem_write = (op_q == OP_SW);
                end
                S_WB: begin
                    reg_write  = 1'b1;
                    reg_dst    = (op_q == OP_R);
                    mem_to_reg = (op_q == OP_LW);
                end
                S_BR: begin
                    ALUop     = ALU_SUBU;
                    branch    = 1'b1;
                    branch_ne = (op_q == OP_BNE);
                end
                S_JMP: begin
                    pc_write  = 1'b1;
                    jump      = 1'b1;
                    link      = (op_q == OP_JAL);
                    reg_write = (op_q == OP_JAL);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/multicycle_ctr.md
# multicycle_ctr

- Multicycle main control FSM for the MIPS CPU.
- Sequences each instruction through fetch, decode, execute, memory and write-back states.
- Produces the datapath strobes and the 3-bit ALUop that the downstream ALU control decoder combines with the funct field to select the ALU operation.
- Sits between the instruction register (opcode/funct) and the datapath, and stalls on a memory-ready handshake.

## Interface
Parameters:
- none

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high; one clock, synchronous reset (fixed)
- opcode  input  6  IR[31:26], valid from ID state onward
- funct  input  6  IR[5:0], used only to detect jr (001000) when opcode=000000
- mem_ready  input  1  memory completes the current access this cycle
- ALUop  output  3  to ALU control: 000 add, 001 subu, 010 R-type, 011 and, 100 or, 101 lui-shift, 110 sltu, 111 slt
- alu_src  output  1  ALU B = extended immediate
- ext_sign  output  1  1 sign-extend, 0 zero-extend immediate
- reg_dst  output  1  write register = rd (else rt)
- mem_to_reg  output  1  write-back data from memory
- reg_write  output  1  register file write enable
- mem_read  output  1  memory read request
- mem_write  output  1  memory write request
- ir_write  output  1  load IR
- pc_write  output  1  unconditional PC update
- branch  output  1  conditional PC update on zero
- branch_ne  output  1  invert branch condition (bne)
- jump  output  1  PC = jump target
- jump_reg  output  1  PC = rs (jr)
- link  output  1  write PC+4 to $31 (jal)
- illegal  output  1  unsupported opcode, one-cycle pulse in ID
- state  output  3  current state code, for debug

## Operation
States:
- IF=0
- ID=1
- EX=2
- MEM=3
- WB=4
- BR=5
- JMP=6
- Codes 7 and undefined codes go to IF.

Opcode classes:
- R 000000
- j 000010
- jal 000011
- beq 000100
- bne 000101
- addi 001000
- slti 001010
- sltiu 001011
- andi 001100
- ori 001101
- lui 001111
- lw 100011
- sw 101011
- Any other opcode is illegal.

Opcode latching:
- In ID, opcode/funct are registered into op_q/jr_q.
- EX/MEM/WB/BR/JMP outputs decode op_q only.

Transitions:
- IF -> ID when mem_ready, else hold.
- ID -> BR (beq/bne), JMP (j/jal), IF (illegal, illegal=1), else EX.
- EX -> MEM (lw/sw), IF (jr), else WB.
- MEM -> WB (lw) or IF (sw) when mem_ready, else hold.
- WB, BR, JMP -> IF.

Outputs (Moore, all default 0, ALUop default 000):
- IF: mem_read=1; ir_write=pc_write=mem_ready.
- EX:
  - ALUop by class: R 010, addi/lw/sw 000, andi 011, ori 100, lui 101, sltiu 110, slti 111.
  - alu_src=1 for all non-R.
  - ext_sign=1 for addi/slti/sltiu/lw/sw.
  - jr: pc_write=jump_reg=1.
- MEM: lw mem_read=1, sw mem_write=1, held until mem_ready.
- WB: reg_write=1; reg_dst=1 for R; mem_to_reg=1 for lw.
- BR: ALUop=001, branch=1, branch_ne=1 for bne.
- JMP: pc_write=jump=1; jal also link=reg_write=1.

## Timing
- Reset:
  - While reset=1, every output is forced to 0 and state reads 0.
  - On the next edge, state=IF and op_q=0.
  - Reset mid-instruction (including a held MEM) aborts it; mem_write/reg_write drop in the same cycle reset rises.
- Cycles with mem_ready always 1:
  - beq/bne/j/jal/jr: 3
  - R/I-ALU/sw: 4
  - lw: 5
- Each mem_ready=0 cycle in IF or MEM adds one cycle.
- While waiting, mem_read/mem_write stay asserted and the address source is unchanged.
- ir_write/pc_write in IF assert only on the mem_ready=1 cycle, exactly once per instruction.
- illegal is combinational from (state==ID, opcode); one cycle wide; the next state is IF.
- jr is R-type with funct 001000: no WB cycle, reg_write never asserted.

## Configuration
- MULTICYCLE_MEMWAIT_EN defined: mem_ready handshake as above.
- Undefined:
  - mem_ready is ignored and treated as 1.
  - IF and MEM each take exactly one cycle.
  - ir_write/pc_write assert unconditionally in IF.

## Test plan
- Reset: hold reset 2 cycles mid-EX -> all outputs 0 during reset, state=0 after release, mem_read=1 next cycle.
- R add (opcode 000000, funct 100000), mem_ready=1 -> states 0,1,2,4; ALUop=010 in EX; reg_write=1 and reg_dst=1 in WB.
- lw with mem_ready low 2 cycles in MEM (macro on) -> states 0,1,2,3,3,3,4; mem_read held; mem_to_reg=reg_write=1 in WB.
- bne (000101) -> states 0,1,5; ALUop=001, branch=branch_ne=1 in BR.
- jal (000011) -> states 0,1,6; pc_write=jump=link=reg_write=1. Then jr (funct 001000) -> 0,1,2 with jump_reg=1 and no reg_write.
- Opcode 111111 -> illegal=1 for exactly the ID cycle, then state=0. sltiu (001011) -> ALUop=110, ext_sign=1, alu_src=1 in EX.
